vending_input_conditioner: RTL

VENDING_INPUT_CONDITIONER -- requirements
Module: vending_input_conditioner

---
 rtl/vending_input_conditioner.sv | 83 ++++++++
 1 files changed

// File: rtl/vending_input_conditioner.sv
// Input conditioning for the vending front panel: per-channel synchronizer,
// debounce counter and registered level/press-strobe outputs.
module vending_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int N_BTN           = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn,
  input  logic             collected,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_pulse,
  output logic             collected_level,
  output logic             collected_pulse
);

  localparam int NCH = N_BTN + 1;
  localparam int CW  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  // Channel N_BTN is the pickup switch; buttons are
  // inverted so every channel is active-high inside.
  logic [NCH-1:0] raw;
  logic [NCH-1:0] sync1;
  logic [NCH-1:0] sync2;
  logic [NCH-1:0] stable;
  logic [NCH-1:0] level_q;
  logic [NCH-1:0] pulse_q;
  logic [CW-1:0]  cnt [NCH];

  assign raw = {collected, ~btn};

  // Two-flop synchronizer against metastability.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Accept a new value only after it holds for
  // DEBOUNCE_CYCLES consecutive synced samples.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stable <= '0;
      for (int i = 0; i < NCH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (sync2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == LAST) begin
          stable[i] <= sync2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // Registered outputs; the strobe fires once per
  // accepted 0->1 change together with the level.
  always_ff @(posedge clk) begin
    if (!rst) begin
      level_q <= '0;
      pulse_q <= '0;
    end else begin
      level_q <= stable;
      pulse_q <= stable & ~level_q;
    end
  end

  assign btn_level       = level_q[N_BTN-1:0];
  assign btn_pulse       = pulse_q[N_BTN-1:0];
  assign collected_level = level_q[N_BTN];
  assign collected_pulse = pulse_q[N_BTN];

endmodule
